// File: rtl/kb_key_tracker_if.sv
// Bundle between the PS/2 receiver / game FSM and kb_key_tracker.
// The master side drives scancode strobes and evt_ready; the slave side is the tracker.
interface kb_key_tracker_if #(
  parameter int PTR_W = 3
);
  logic [7:0]     key_code;
  logic           key_valid;
  logic           key_released;
  logic [7:0]     key_held;
  logic           evt_valid;
  logic [3:0]     evt_data;
  logic           evt_ready;
  logic [PTR_W:0] fifo_count;
  logic           overflow;

  modport master (
    output key_code, key_valid, key_released, evt_ready,
    input  key_held, evt_valid, evt_data, fifo_count, overflow
  );

  modport slave (
    input  key_code, key_valid, key_released, evt_ready,
    output key_held, evt_valid, evt_data, fifo_count, overflow
  );
endinterface

// File: rtl/kb_key_tracker.sv
// Maps PS/2 scancodes of 8 game keys to a held-key bitmap and a press/release event FIFO.
// Optional macro ARROW_ALIAS_EN aliases E0-prefixed arrow keys onto the WASD indices.
module kb_key_tracker #(
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input logic            clk,
  input logic            rst_n,
  kb_key_tracker_if.slave bus
);

  typedef enum logic {NORM, EXT} state_e;

  localparam logic [7:0]     PREFIX_CODE = 8'hE0;
  localparam logic [PTR_W:0] FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        held_q, held_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [3:0]        mem [FIFO_DEPTH];

  logic              is_make, is_strobe, is_prefix;
  logic              hit;
  logic [2:0]        idx;
  logic              push, push_ok, pop, full;
  logic [3:0]        push_data;

  // A simultaneous break strobe overrides the make strobe.
  assign is_strobe = bus.key_valid | bus.key_released;
  assign is_make   = bus.key_valid & ~bus.key_released;
  assign is_prefix = is_make && (bus.key_code == PREFIX_CODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= NORM;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_prefix)      state_d = EXT;
    else if (is_strobe) state_d = NORM;
  end

  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    if (is_strobe && !is_prefix) begin
      if (state_q == NORM) begin
        hit = 1'b1;
        case (bus.key_code)
          8'h1D:   idx = 3'd0;
          8'h1C:   idx = 3'd1;
          8'h1B:   idx = 3'd2;
          8'h23:   idx = 3'd3;
          8'h29:   idx = 3'd4;
          8'h5A:   idx = 3'd5;
          8'h76:   idx = 3'd6;
          8'h4D:   idx = 3'd7;
          default: hit = 1'b0;
        endcase
      end else begin
`ifdef ARROW_ALIAS_EN
        hit = 1'b1;
        case (bus.key_code)
          8'h75:   idx = 3'd0;
          8'h6B:   idx = 3'd1;
          8'h72:   idx = 3'd2;
          8'h74:   idx = 3'd3;
          default: hit = 1'b0;
        endcase
`else
        hit = 1'b0;
`endif
      end
    end
  end

  // Only edges of the held bitmap produce events, which filters typematic repeats.
  always_comb begin
    held_d    = held_q;
    push      = 1'b0;
    push_data = {is_make, idx};
    if (hit) begin
      if (is_make && !held_q[idx]) begin
        held_d[idx] = 1'b1;
        push        = 1'b1;
      end else if (!is_make && held_q[idx]) begin
        held_d[idx] = 1'b0;
        push        = 1'b1;
      end
    end
  end

  assign full    = (count_q == FULL_COUNT);
  assign pop     = (count_q != '0) && bus.evt_ready;
  assign push_ok = push && (!full || pop);

  always_comb begin
    count_d = count_q + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
    ovf_d   = ovf_q | (push && !push_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      held_q  <= held_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign bus.key_held   = held_q;
  assign bus.evt_valid  = (count_q != '0);
  assign bus.evt_data   = (count_q != '0) ? mem[rd_ptr_q] : 4'h0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_kb_key_tracker.sv
// Self-checking bench for kb_key_tracker: directed scenarios plus randomized traffic
// compared against a queue-based reference model. Honours ARROW_ALIAS_EN like the DUT.
module tb_kb_key_tracker;

  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   vecCount;
  int   missCount;

  logic [7:0] mHeld;
  logic [3:0] mQ[$];
  bit         mOvf;
  bit         mExt;

  kb_key_tracker_if #(.PTR_W(3)) bus ();

  kb_key_tracker #(.FIFO_DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key index for a code, or -1 when the code is not a game key.
  function automatic int mapCode(input bit ext, input logic [7:0] c);
    if (!ext) begin
      case (c)
        8'h1D: return 0;
        8'h1C: return 1;
        8'h1B: return 2;
        8'h23: return 3;
        8'h29: return 4;
        8'h5A: return 5;
        8'h76: return 6;
        8'h4D: return 7;
        default: return -1;
      endcase
    end
`ifdef ARROW_ALIAS_EN
    case (c)
      8'h75: return 0;
      8'h6B: return 1;
      8'h72: return 2;
      8'h74: return 3;
      default: return -1;
    endcase
`else
    return -1;
`endif
  endfunction

  function automatic logic [3:0] mHead();
    return (mQ.size() != 0) ? mQ[0] : 4'h0;
  endfunction

  task automatic modelReset();
    mHeld = '0;
    mQ.delete();
    mOvf  = 1'b0;
    mExt  = 1'b0;
  endtask

  task automatic applyStimulus(input logic v, input logic r, input logic [7:0] c, input logic rdy);
    bit         mk, popped, full, have;
    int         k;
    logic [3:0] ev;
    bus.key_valid    = v;
    bus.key_released = r;
    bus.key_code     = c;
    bus.evt_ready    = rdy;
    @(posedge clk);
    popped = (mQ.size() != 0) && rdy;
    full   = (mQ.size() == DEPTH);
    have   = 1'b0;
    ev     = 4'h0;
    if (v || r) begin
      mk = v && !r;
      if (mk && c == 8'hE0) mExt = 1'b1;
      else begin
        k    = mapCode(mExt, c);
        mExt = 1'b0;
        if (k >= 0) begin
          if (mk && !mHeld[k]) begin
            mHeld[k] = 1'b1; ev = {1'b1, 3'(k)}; have = 1'b1;
          end else if (!mk && mHeld[k]) begin
            mHeld[k] = 1'b0; ev = {1'b0, 3'(k)}; have = 1'b1;
          end
        end
      end
    end
    if (popped) void'(mQ.pop_front());
    if (have) begin
      if (!full || popped) mQ.push_back(ev);
      else                 mOvf = 1'b1;
    end
    @(negedge clk);
    bus.key_valid    = 1'b0;
    bus.key_released = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    vecCount++;
    if (bus.key_held !== 8'h00) begin missCount++; $display("[TB] FAIL reset_held: got %h expected 00", bus.key_held); end
    vecCount++;
    if (bus.evt_valid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.evt_valid); end
    vecCount++;
    if (bus.evt_data !== 4'h0) begin missCount++; $display("[TB] FAIL reset_data: got %h expected 0", bus.evt_data); end
    vecCount++;
    if (bus.fifo_count !== 4'd0) begin missCount++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.fifo_count); end
    vecCount++;
    if (bus.overflow !== 1'b0) begin missCount++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus.overflow); end
  endtask

  task automatic test_make_break();
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h1D, 1'b1);
    vecCount++;
    if (bus.key_held !== 8'h01) begin missCount++; $display("[TB] FAIL mb_held_press: got %h expected 01", bus.key_held); end
    vecCount++;
    if (bus.evt_valid !== 1'b1 || bus.evt_data !== 4'b1000) begin
      missCount++; $display("[TB] FAIL mb_press_evt: got v=%b d=%b expected v=1 d=1000", bus.evt_valid, bus.evt_data);
    end
    applyStimulus(1'b0, 1'b1, 8'h1D, 1'b1);
    vecCount++;
    if (bus.key_held !== 8'h00) begin missCount++; $display("[TB] FAIL mb_held_release: got %h expected 00", bus.key_held); end
    vecCount++;
    if (bus.evt_data !== 4'b0000 || bus.fifo_count !== 4'd1) begin
      missCount++; $display("[TB] FAIL mb_release_evt: got d=%b cnt=%0d expected d=0000 cnt=1", bus.evt_data, bus.fifo_count);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    vecCount++;
    if (bus.fifo_count !== 4'd0 || bus.evt_valid !== 1'b0) begin
      missCount++; $display("[TB] FAIL mb_drained: got cnt=%0d v=%b expected cnt=0 v=0", bus.fifo_count, bus.evt_valid);
    end
  endtask

  task automatic test_repeat();
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 8'h1D, 1'b0);
    vecCount++;
    if (bus.fifo_count !== 4'd1 || bus.evt_data !== 4'b1000) begin
      missCount++; $display("[TB] FAIL repeat: got cnt=%0d d=%b expected cnt=1 d=1000", bus.fifo_count, bus.evt_data);
    end
  endtask

  task automatic test_ignored();
    doReset();
    applyStimulus(1'b0, 1'b1, 8'h29, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h15, 1'b0);
    vecCount++;
    if (bus.evt_valid !== 1'b0 || bus.key_held !== 8'h00 || bus.overflow !== 1'b0) begin
      missCount++; $display("[TB] FAIL ignored: got v=%b held=%h ovf=%b expected 0/00/0", bus.evt_valid, bus.key_held, bus.overflow);
    end
    applyStimulus(1'b1, 1'b1, 8'h1C, 1'b0);
    vecCount++;
    if (bus.evt_valid !== 1'b0 || bus.key_held !== 8'h00) begin
      missCount++; $display("[TB] FAIL both_strobes: got v=%b held=%h expected 0/00", bus.evt_valid, bus.key_held);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [8];
    logic [3:0] order [8];
    codes = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h4D};
    order = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000};
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, codes[i], 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h1D, 1'b0);
    vecCount++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b1) begin
      missCount++; $display("[TB] FAIL ovf_full: got cnt=%0d ovf=%b expected cnt=8 ovf=1", bus.fifo_count, bus.overflow);
    end
    vecCount++;
    if (bus.evt_data !== 4'b1000 || bus.key_held !== 8'hFE) begin
      missCount++; $display("[TB] FAIL ovf_head_held: got d=%b held=%h expected d=1000 held=fe", bus.evt_data, bus.key_held);
    end
    applyStimulus(1'b1, 1'b0, 8'h1D, 1'b1);
    vecCount++;
    if (bus.fifo_count !== 4'd8 || bus.overflow !== 1'b1 || bus.evt_data !== 4'b1001) begin
      missCount++; $display("[TB] FAIL full_push_pop: got cnt=%0d ovf=%b d=%b expected 8/1/1001", bus.fifo_count, bus.overflow, bus.evt_data);
    end
    for (int i = 0; i < 8; i++) begin
      vecCount++;
      if (bus.evt_valid !== 1'b1 || bus.evt_data !== order[i]) begin
        missCount++; $display("[TB] FAIL drain_%0d: got v=%b d=%b expected v=1 d=%b", i, bus.evt_valid, bus.evt_data, order[i]);
      end
      applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    end
    vecCount++;
    if (bus.fifo_count !== 4'd0 || bus.overflow !== 1'b1) begin
      missCount++; $display("[TB] FAIL drain_end: got cnt=%0d ovf=%b expected 0/1", bus.fifo_count, bus.overflow);
    end
  endtask

  task automatic test_prefix();
    logic [3:0] expHead;
    logic [3:0] expCnt;
    logic [7:0] expHeld;
`ifdef ARROW_ALIAS_EN
    expHead = 4'b1000; expCnt = 4'd2; expHeld = 8'h03;
`else
    expHead = 4'b1001; expCnt = 4'd1; expHeld = 8'h02;
`endif
    doReset();
    applyStimulus(1'b1, 1'b0, 8'hE0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h75, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h1C, 1'b0);
    vecCount++;
    if (bus.evt_data !== expHead || bus.fifo_count !== expCnt || bus.key_held !== expHeld) begin
      missCount++; $display("[TB] FAIL prefix: got d=%b cnt=%0d held=%h expected d=%b cnt=%0d held=%h",
                            bus.evt_data, bus.fifo_count, bus.key_held, expHead, expCnt, expHeld);
    end
    doReset();
    applyStimulus(1'b1, 1'b0, 8'hE0, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h5A, 1'b0);
    vecCount++;
    if (bus.evt_valid !== 1'b0 || bus.key_held !== 8'h00) begin
      missCount++; $display("[TB] FAIL keypad_enter: got v=%b held=%h expected 0/00", bus.evt_valid, bus.key_held);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h29, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'hE0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    vecCount++;
    if (bus.key_held !== 8'h00 || bus.evt_valid !== 1'b0 || bus.evt_data !== 4'h0 || bus.fifo_count !== 4'd0) begin
      missCount++; $display("[TB] FAIL async_reset: got held=%h v=%b d=%h cnt=%0d expected all zero",
                            bus.key_held, bus.evt_valid, bus.evt_data, bus.fifo_count);
    end
    rst_n = 1'b1;
    modelReset();
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h1C, 1'b0);
    vecCount++;
    if (bus.evt_data !== 4'b1001 || bus.fifo_count !== 4'd1) begin
      missCount++; $display("[TB] FAIL ext_cleared: got d=%b cnt=%0d expected 1001/1", bus.evt_data, bus.fifo_count);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool [15];
    logic [7:0] c;
    logic       v, r, rdy;
    int         sel;
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h5A, 8'h76, 8'h4D,
             8'hE0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'h15, 8'hE0};
    doReset();
    for (int i = 0; i < 600; i++) begin
      sel = $urandom_range(0, 9);
      v   = (sel < 6);
      r   = (sel >= 4 && sel < 9);
      c   = pool[$urandom_range(0, 14)];
      rdy = ((i / 40) % 3 == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
      applyStimulus(v, r, c, rdy);
      vecCount++;
      if (bus.key_held !== mHeld || bus.fifo_count !== 4'(mQ.size()) || bus.evt_valid !== (mQ.size() != 0) ||
          bus.evt_data !== mHead() || bus.overflow !== mOvf) begin
        missCount++;
        $display("[TB] FAIL random_%0d: got held=%h cnt=%0d v=%b d=%b ovf=%b expected held=%h cnt=%0d v=%b d=%b ovf=%b",
                 i, bus.key_held, bus.fifo_count, bus.evt_valid, bus.evt_data, bus.overflow,
                 mHeld, mQ.size(), (mQ.size() != 0), mHead(), mOvf);
      end
    end
  endtask

  initial begin
    vecCount         = 0;
    missCount        = 0;
    rst_n            = 1'b0;
    bus.key_code     = 8'h00;
    bus.key_valid    = 1'b0;
    bus.key_released = 1'b0;
    bus.evt_ready    = 1'b0;
    modelReset();
    #2;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_make_break();
    test_repeat();
    test_ignored();
    test_overflow();
    test_prefix();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/kb_key_tracker.md
Name: kb_key_tracker

Overview:
Sits directly downstream of the PS/2 scancode receiver. Consumes its single-cycle key_valid / key_released strobes and the key_code byte, and handles the E0 extended prefix. Maps 8 game keys to indices and keeps a held-key bitmap. Typematic repeats are suppressed, and press/release events are queued in a small FIFO for the game-logic FSM.

Parameters:
FIFO_DEPTH, 8, event queue depth; power of 2, 2..16
PTR_W, 3, log2(FIFO_DEPTH); must match FIFO_DEPTH

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
key_code  in  8  scancode byte from receiver, valid with either strobe
key_valid  in  1  1-cycle make strobe (also fires for the E0 prefix byte)
key_released  in  1  1-cycle break strobe (the F0 byte is already stripped upstream)
key_held  out  8  bit i = 1 while mapped key i is down
evt_valid  out  1  queue non-empty
evt_data  out  4  head event: [3]=1 press / 0 release, [2:0] key index
evt_ready  in  1  consumer pops head when evt_valid && evt_ready
fifo_count  out  PTR_W+1  entries queued, 0..FIFO_DEPTH
overflow  out  1  sticky: an event was dropped because the queue was full

Behaviour:
- Reset (asynchronous, rst_n=0) clears the following, all effective immediately mid-operation:
  - outputs: key_held=0, evt_valid=0, evt_data=0, fifo_count=0, overflow=0
  - internal state: ext flag=0, read/write pointers=0
  - Queued events are discarded.
- Strobe priority: if key_valid and key_released are both high, key_released wins and key_valid is ignored.
- Prefix FSM, states NORM and EXT:
  - NORM: key_valid with code E0 -> EXT, no other action.
  - NORM: any other strobe -> decoded with the base table.
  - EXT: the next strobe (make or break) is decoded with the extended table, then -> NORM.
  - EXT: key_valid with code E0 again stays EXT.
  - EXT: codes not in the extended table are ignored and return to NORM.
- Base table (index:code):
  - 0:1D (W), 1:1C (A), 2:1B (S), 3:23 (D)
  - 4:29 (Space), 5:5A (Enter), 6:76 (Esc), 7:4D (P)
  - Unmapped codes are ignored.
- Extended table: empty unless ARROW_ALIAS_EN is defined. Without the feature, E0 5A (keypad Enter) is NOT index 5.
- Make of mapped key i:
  - key_held[i]=0 -> set key_held[i], push {1,i}.
  - key_held[i]=1 -> typematic repeat: no push, no change.
- Break of mapped key i:
  - key_held[i]=1 -> clear key_held[i], push {0,i}.
  - key_held[i]=0 -> ignored, no push.
- Latency: strobe in cycle N -> key_held updated and event visible at the queue tail in cycle N+1. With the queue empty, evt_valid=1 in cycle N+1 and evt_data shows the new event (first-word fall-through).
- FIFO:
  - evt_data is the head entry; it holds stable while evt_valid && !evt_ready.
  - Pop and push in the same cycle: both occur, count unchanged. This is allowed even when full, because the pop frees the slot.
  - Push while full without a pop: the event is dropped, overflow is set (stays 1 until reset), and key_held still updates.
  - Pop while empty: no effect; pointers and count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- fifo_count is registered and exact.

Optional Feature:
ARROW_ALIAS_EN
- Defined: extended table maps arrow keys onto WASD indices: E0 75 (up)->0, E0 6B (left)->1, E0 72 (down)->2, E0 74 (right)->3.
- The held and repeat rules are shared: W make followed by Up make gives a single press event.
- Undefined: all E0-prefixed codes are ignored; the E0 prefix is still consumed so the following byte is never mis-decoded as a base key.

Test Plan:
- Make 1D, then break 1D, evt_ready=1 -> key_held[0]: 1 at N+1, back to 0 after the break. Events 4'b1000 then 4'b0000; fifo_count returns to 0.
- Make 1D x5 (repeat) with evt_ready=0 -> exactly one event 4'b1000, fifo_count=1.
- Break 29 with Space not held; make 15 (unmapped) -> no events, key_held=0, overflow=0.
- evt_ready=0, 9 distinct press/release events with FIFO_DEPTH=8 -> fifo_count=8 and overflow=1. The head is the first event; the 9th event is lost, but key_held reflects all 9.
- FIFO full, then push + pop in the same cycle -> fifo_count stays 8, overflow unchanged. Draining returns events in order.
- Make E0, then make 75:
  - ARROW_ALIAS_EN defined -> key_held[0]=1, event 4'b1000.
  - Undefined -> no event.
  - In both cases, a following make 1C still yields 4'b1001.
